// File: rtl/uart_tx_msg_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_msg_arbiter
//
// Shares one uart_tx byte transmitter among NUM_REQ packet sources (gesture
// result, periodic status, debug dump). Each grant takes one packet of one or
// two bytes. The bytes go to uart_tx over a tx_data/tx_valid/tx_busy handshake.
// A watchdog aborts the packet if the transmitter never reports busy.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset (synchronous release upstream)
//   req_valid  : per-requester packet-available flag, held until req_ready
//   req_data   : 16 bits per requester, byte0 = upper byte, byte1 = lower byte
//   req_len    : per-requester length, 0 = byte0 only, 1 = byte0 then byte1
//   req_ready  : one-cycle pulse, the packet of that requester has been latched
//   tx_data    : byte presented to uart_tx
//   tx_valid   : one-cycle start pulse to uart_tx
//   tx_busy    : uart_tx busy flag
//   active_id  : index of the requester being served
//   arb_busy   : high whenever the scheduler is not idle
//   err_count  : saturating count of busy-timeout aborts
// ---------------------------------------------------------------------------
module uart_tx_msg_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int BUSY_TIMEOUT = 16,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]     req_len,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_busy,
    output logic [ID_W-1:0]        active_id,
    output logic                   arb_busy,
    output logic [7:0]             err_count
);

    localparam int TMR_W = $clog2(BUSY_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND0 = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_SEND1 = 3'd3,
        ST_WAIT1 = 3'd4
    } state_t;

    state_t             state_r,     state_s;
    logic [ID_W-1:0]    last_r,      last_s;
    logic [7:0]         byte0_r,     byte0_s;
    logic [7:0]         byte1_r,     byte1_s;
    logic               len_r,       len_s;
    logic [TMR_W-1:0]   timer_r,     timer_s;
    logic [7:0]         tx_data_r,   tx_data_s;
    logic               tx_valid_r,  tx_valid_s;
    logic [NUM_REQ-1:0] req_ready_r, req_ready_s;
    logic [ID_W-1:0]    active_id_r, active_id_s;
    logic               arb_busy_r,  arb_busy_s;
    logic [7:0]         err_count_r, err_count_s;

    logic               gnt_found_s;
    logic [ID_W-1:0]    gnt_id_s;
    logic [7:0]         gnt_b0_s;
    logic [7:0]         gnt_b1_s;
    logic               gnt_len_s;
    logic               timeout_s;

    // Error counter sticks at its maximum instead of wrapping to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

    // Round-robin search: priority distance k runs from lowest (NUM_REQ) to
    // highest (1) so the last matching assignment is the winner.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_id_s    = {ID_W{1'b0}};
        gnt_b0_s    = 8'h00;
        gnt_b1_s    = 8'h00;
        gnt_len_s   = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] &&
                    ((i == int'(last_r) + k) || (i == int'(last_r) + k - NUM_REQ))) begin
                    gnt_found_s = 1'b1;
                    gnt_id_s    = ID_W'(i);
                    gnt_b0_s    = req_data[16*i+8 +: 8];
                    gnt_b1_s    = req_data[16*i +: 8];
                    gnt_len_s   = req_len[i];
                end else begin
                    gnt_found_s = gnt_found_s;
                end
            end
        end
    end

    // Next-state and next-output logic for the scheduler FSM.
    always_comb begin
        state_s     = state_r;
        last_s      = last_r;
        byte0_s     = byte0_r;
        byte1_s     = byte1_r;
        len_s       = len_r;
        timer_s     = timer_r;
        tx_data_s   = tx_data_r;
        tx_valid_s  = 1'b0;
        req_ready_s = {NUM_REQ{1'b0}};
        active_id_s = active_id_r;
        err_count_s = err_count_r;
        timeout_s   = (timer_r == TMR_W'(BUSY_TIMEOUT - 1));

        case (state_r)
            ST_IDLE: begin
                if (gnt_found_s) begin
                    byte0_s     = gnt_b0_s;
                    byte1_s     = gnt_b1_s;
                    len_s       = gnt_len_s;
                    active_id_s = gnt_id_s;
                    last_s      = gnt_id_s;
                    req_ready_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id_s;
                    state_s     = ST_SEND0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            // A busy transmitter here means the previous byte is still
            // shifting out; wait indefinitely, the watchdog is not armed yet.
            ST_SEND0: begin
                if (!tx_busy) begin
                    tx_data_s  = byte0_r;
                    tx_valid_s = 1'b1;
                    timer_s    = {TMR_W{1'b0}};
                    state_s    = ST_WAIT0;
                end else begin
                    state_s = ST_SEND0;
                end
            end
            ST_WAIT0: begin
                if (tx_busy) begin
                    state_s = len_r ? ST_SEND1 : ST_IDLE;
                end else if (timeout_s) begin
                    err_count_s = sat_inc8(err_count_r);
                    state_s     = ST_IDLE;
                end else begin
                    timer_s = timer_r + TMR_W'(1'b1);
                end
            end
            ST_SEND1: begin
                if (!tx_busy) begin
                    tx_data_s  = byte1_r;
                    tx_valid_s = 1'b1;
                    timer_s    = {TMR_W{1'b0}};
                    state_s    = ST_WAIT1;
                end else begin
                    state_s = ST_SEND1;
                end
            end
            ST_WAIT1: begin
                if (tx_busy) begin
                    state_s = ST_IDLE;
                end else if (timeout_s) begin
                    err_count_s = sat_inc8(err_count_r);
                    state_s     = ST_IDLE;
                end else begin
                    timer_s = timer_r + TMR_W'(1'b1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        arb_busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset discards any in-flight packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            last_r      <= ID_W'(NUM_REQ - 1);
            byte0_r     <= 8'h00;
            byte1_r     <= 8'h00;
            len_r       <= 1'b0;
            timer_r     <= {TMR_W{1'b0}};
            tx_data_r   <= 8'h00;
            tx_valid_r  <= 1'b0;
            req_ready_r <= {NUM_REQ{1'b0}};
            active_id_r <= {ID_W{1'b0}};
            arb_busy_r  <= 1'b0;
            err_count_r <= 8'h00;
        end else begin
            state_r     <= state_s;
            last_r      <= last_s;
            byte0_r     <= byte0_s;
            byte1_r     <= byte1_s;
            len_r       <= len_s;
            timer_r     <= timer_s;
            tx_data_r   <= tx_data_s;
            tx_valid_r  <= tx_valid_s;
            req_ready_r <= req_ready_s;
            active_id_r <= active_id_s;
            arb_busy_r  <= arb_busy_s;
            err_count_r <= err_count_s;
        end
    end

    assign req_ready = req_ready_r;
    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign active_id = active_id_r;
    assign arb_busy  = arb_busy_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_uart_tx_msg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_msg_arbiter
//
// Self-checking bench for uart_tx_msg_arbiter. A small uart_tx model raises
// tx_busy two cycles after each tx_valid and holds it for BUSY_LEN cycles;
// it can also be forced stuck low or stuck high. Expected bytes and their
// requester ids are queued when a packet is offered and compared when the
// DUT pulses tx_valid.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_msg_arbiter;

    localparam int NUM_REQ      = 3;
    localparam int BUSY_TIMEOUT = 16;
    localparam int ID_W         = 2;
    localparam int BUSY_LEN     = 4;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_len;
    logic [NUM_REQ-1:0]    req_ready;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_busy;
    logic [ID_W-1:0]       active_id;
    logic                  arb_busy;
    logic [7:0]            err_count;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [7:0]      b;
    } exp_t;

    typedef struct {
        int          id;
        logic [15:0] data;
        logic        len;
        int          nbytes;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[5];

    int   n_tests;
    int   n_fail;
    int   cyc;
    int   ntx;
    int   first_tx_cyc;
    bit   ff_seen;
    int   mode;        // 0 model, 1 busy stuck low, 2 busy stuck high
    bit   m_busy;
    int   m_dly;
    int   m_left;

    assign tx_busy = (mode == 2) ? 1'b1 : ((mode == 1) ? 1'b0 : m_busy);

    uart_tx_msg_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_len   (req_len),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_busy   (tx_busy),
        .active_id (active_id),
        .arb_busy  (arb_busy),
        .err_count (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [7:0] b);
        exp_t e;
        e.id = ID_W'(id);
        e.b  = b;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor followed by the uart_tx model, both on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tx_valid) begin
                    ntx++;
                    if (first_tx_cyc < 0) first_tx_cyc = cyc;
                    check("tx_valid_while_busy", 32'(tx_busy), 32'd0);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_tx: got byte 0x%0h required none", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", 32'(tx_data), 32'(e.b));
                        check("tx_active_id", 32'(active_id), 32'(e.id));
                    end
                end
                if (tx_data == 8'hFF) ff_seen = 1'b1;
                if (req_ready != '0) check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            end
            if (!rst_n) begin
                m_busy = 1'b0;
                m_dly  = 0;
                m_left = 0;
            end else if (tx_valid) begin
                m_dly = 1;
            end else if (m_dly != 0) begin
                m_dly  = 0;
                m_busy = 1'b1;
                m_left = BUSY_LEN;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end
        end
    end

    task automatic wait_idle(input string name);
        int c = 0;
        while ((arb_busy || tx_busy || exp_q.size() != 0) && c < 500) begin
            @(negedge clk);
            c++;
        end
        check({name, "_idle_bound"}, 32'(c < 500), 32'd1);
    endtask

    task automatic wait_ready(input int id, input string name, output int rdy_cyc);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!req_ready[id] && c < 200);
        check({name, "_ready"}, 32'(req_ready[id]), 32'd1);
        check({name, "_grant_id"}, 32'(active_id), 32'(id));
        rdy_cyc = cyc;
        req_valid[id] = 1'b0;
    endtask

    task automatic offer(input int id, input logic [15:0] data, input logic len);
        req_data[16*id +: 16] = data;
        req_len[id]           = len;
        req_valid[id]         = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int start_cyc;
        int rdy_cyc;
        @(negedge clk);
        push_exp(v.id, v.b0);
        if (v.nbytes == 2) push_exp(v.id, v.b1);
        first_tx_cyc = -1;
        start_cyc    = cyc;
        offer(v.id, v.data, v.len);
        wait_ready(v.id, name, rdy_cyc);
        @(negedge clk);
        check({name, "_ready_pulse"}, 32'(req_ready), 32'd0);
        wait_idle(name);
        check({name, "_lat_ready"}, 32'(rdy_cyc - start_cyc), 32'd1);
        check({name, "_lat_tx"}, 32'(first_tx_cyc - rdy_cyc), 32'd1);
    endtask

    // Counts grants while requests stay asserted; grant g must go to g % NUM_REQ.
    task automatic rr_run(input int n, input string name);
        int g = 0;
        int c = 0;
        while (g < n && c < 1000) begin
            @(negedge clk);
            c++;
            if (req_ready != '0) begin
                check({name, "_id"}, 32'(active_id), 32'(g % NUM_REQ));
                check({name, "_ready_vec"}, 32'(req_ready), 32'(1 << (g % NUM_REQ)));
                g++;
            end
        end
        req_valid = '0;
        check({name, "_grants"}, 32'(g), 32'(n));
        wait_idle(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_len   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int c;
        int n0;
        int cnt;
        int rdy;
        n_tests = 0; n_fail = 0; ntx = 0; first_tx_cyc = -1; ff_seen = 1'b0;
        mode = 0; m_busy = 1'b0; m_dly = 0; m_left = 0;
        req_valid = '0; req_data = '0; req_len = '0;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_valid",  32'(tx_valid),  32'd0);
        check("rst_tx_data",   32'(tx_data),   32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_active_id", 32'(active_id), 32'd0);
        check("rst_arb_busy",  32'(arb_busy),  32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-requester packets, one- and two-byte, every source.
        vecs[0] = '{0, 16'hA25C, 1'b1, 2, 8'hA2, 8'h5C};
        vecs[1] = '{1, 16'hC3FF, 1'b0, 1, 8'hC3, 8'h00};
        vecs[2] = '{2, 16'h0F96, 1'b1, 2, 8'h0F, 8'h96};
        vecs[3] = '{1, 16'h8001, 1'b1, 2, 8'h80, 8'h01};
        vecs[4] = '{0, 16'h00FF, 1'b0, 1, 8'h00, 8'h00};
        ff_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            check($sformatf("vec%0d_arb_idle", i), 32'(arb_busy), 32'd0);
        end
        check("len0_byte1_hidden", 32'(ff_seen), 32'd0);
        check("vec_err_count", 32'(err_count), 32'd0);

        // All three requesting continuously: strict rotation from requester 0.
        do_reset();
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            push_exp(0, 8'h11);
            push_exp(1, 8'h22);
            push_exp(2, 8'h33);
        end
        offer(0, 16'h11AA, 1'b0);
        offer(1, 16'h22BB, 1'b0);
        offer(2, 16'h33CC, 1'b0);
        rr_run(6, "rr3");

        // Transmitter never goes busy: one tx_valid, abort after the timeout.
        @(negedge clk);
        mode = 1;
        push_exp(0, 8'h7E);
        n0 = ntx;
        first_tx_cyc = -1;
        offer(0, 16'h7E81, 1'b1);
        wait_ready(0, "to", rdy);
        c = 0;
        while (arb_busy && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("to_duration", 32'(cyc - first_tx_cyc), 32'(BUSY_TIMEOUT));
        check("to_ntx", 32'(ntx - n0), 32'd1);
        check("to_err_count", 32'(err_count), 32'd1);
        check("to_queue_empty", 32'(exp_q.size()), 32'd0);
        mode = 0;
        run_vec('{1, 16'h5A00, 1'b0, 1, 8'h5A, 8'h00}, "after_to");
        check("to_err_hold", 32'(err_count), 32'd1);

        // Reset while waiting for busy after the second byte.
        @(negedge clk);
        push_exp(0, 8'h12);
        push_exp(0, 8'h34);
        offer(0, 16'h1234, 1'b1);
        wait_ready(0, "rst", rdy);
        c = 0;
        cnt = 0;
        while (cnt < 2 && c < 200) begin
            @(negedge clk);
            c++;
            if (tx_valid) cnt++;
        end
        check("rst_reach_wait1", 32'(cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_valid",  32'(tx_valid),  32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd0);
        check("rst_mid_arb_busy",  32'(arb_busy),  32'd0);
        check("rst_mid_err_count", 32'(err_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_exp(0, 8'h0A);
        push_exp(1, 8'h0B);
        offer(1, 16'h0B00, 1'b0);
        offer(0, 16'h0A00, 1'b0);
        rr_run(2, "post_rst");

        // Transmitter busy for 100 cycles at grant: SEND0 stalls without timeout.
        @(negedge clk);
        mode = 2;
        push_exp(2, 8'h99);
        n0 = ntx;
        offer(2, 16'h9900, 1'b0);
        wait_ready(2, "stall", rdy);
        repeat (100) @(negedge clk);
        check("stall_no_tx", 32'(ntx - n0), 32'd0);
        check("stall_arb_busy", 32'(arb_busy), 32'd1);
        check("stall_err_count", 32'(err_count), 32'd0);
        mode = 0;
        wait_idle("stall");
        check("stall_sent", 32'(ntx - n0), 32'd1);
        check("stall_err_final", 32'(err_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
